// File: rtl/conv_win_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | conv_win_sched_if : controller <-> window scheduler signal bundle           |
// | Optional CONV_SCHED_PERF_EN adds the stall_cnt performance counter.         |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
interface conv_win_sched_if #(
  parameter int CNT_W = 12
);
  logic             start;
  logic [CNT_W-1:0] width;
  logic [CNT_W-1:0] channel;
  logic [2:0]       stride;
  logic             win_ready;
  logic             agen_rst;
  logic             addr_inc;
  logic             win_valid;
  logic             win_last;
  logic             busy;
  logic             done;
  logic             cfg_err;
`ifdef CONV_SCHED_PERF_EN
  logic [31:0]      stall_cnt;
`endif

  modport master (
    output start, width, channel, stride, win_ready,
    input  agen_rst, addr_inc, win_valid, win_last, busy, done, cfg_err
`ifdef CONV_SCHED_PERF_EN
    , input stall_cnt
`endif
  );

  modport slave (
    input  start, width, channel, stride, win_ready,
    output agen_rst, addr_inc, win_valid, win_last, busy, done, cfg_err
`ifdef CONV_SCHED_PERF_EN
    , output stall_cnt
`endif
  );
endinterface
`default_nettype wire

// File: rtl/conv_win_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | conv_win_sched : 3x3 window issue sequencer with credit flow control and   |
// | BRAM latency tracking. Macro CONV_SCHED_PERF_EN adds stall_cnt.            |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module conv_win_sched #(
  parameter int BRAM_LAT = 2,
  parameter int CREDITS  = 4,
  parameter int CNT_W    = 12
) (
  input  logic              clk,
  input  logic              rst,
  conv_win_sched_if.slave   bus
);
  localparam int                 c_OUT_W   = $clog2(CREDITS + 1);
  localparam logic [c_OUT_W-1:0] c_CREDITS = c_OUT_W'(CREDITS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_width;
  logic [CNT_W-1:0]   r_channel;
  logic [2:0]         r_stride;
  logic [CNT_W-1:0]   r_col;
  logic [CNT_W-1:0]   r_row;
  logic [CNT_W-1:0]   r_chan;
  logic [c_OUT_W-1:0] r_out;
  logic               r_addr_inc;
  logic               r_agen_rst;
  logic               r_busy;
  logic               r_done;
  logic               r_cfg_err;
  logic [BRAM_LAT-1:0] r_vld_sr;
  logic [BRAM_LAT-1:0] r_last_sr;
`ifdef CONV_SCHED_PERF_EN
  logic [31:0]        r_stall_cnt;
`endif

  logic               w_cfg_bad;
  logic               w_issue;
  logic [CNT_W:0]     w_width_x;
  logic [CNT_W:0]     w_col_span;
  logic [CNT_W:0]     w_row_span;
  logic               w_row_end;
  logic               w_chan_end;
  logic               w_layer_end;
  logic               w_dec;
  logic [c_OUT_W-1:0] w_out_nxt;

  assign w_cfg_bad = (bus.width < CNT_W'(3)) || (bus.channel == '0) ||
                     (bus.stride == 3'd0) || (bus.stride > 3'd4);

  // addr_inc is only ever raised while in RUN, so it is the issue strobe itself
  assign w_issue = r_addr_inc;

  // One extra bit so position+3+stride cannot wrap at the top of the range
  assign w_width_x   = {1'b0, r_width};
  assign w_col_span  = {1'b0, r_col} + (CNT_W+1)'(3) + (CNT_W+1)'(r_stride);
  assign w_row_span  = {1'b0, r_row} + (CNT_W+1)'(3) + (CNT_W+1)'(r_stride);
  assign w_row_end   = w_width_x < w_col_span;
  assign w_chan_end  = w_row_end && (w_width_x < w_row_span);
  assign w_layer_end = w_chan_end && (r_chan == r_channel - CNT_W'(1));

  // A return with nothing outstanding is ignored unless it pairs with an issue
  assign w_dec = bus.win_ready && ((r_out != '0) || w_issue);

  always_comb begin
    w_out_nxt = r_out;
    if (w_issue && !w_dec) begin
      w_out_nxt = r_out + c_OUT_W'(1);
    end else if (!w_issue && w_dec) begin
      w_out_nxt = r_out - c_OUT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_width     <= '0;
      r_channel   <= '0;
      r_stride    <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_chan      <= '0;
      r_out       <= '0;
      r_addr_inc  <= 1'b0;
      r_agen_rst  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_err   <= 1'b0;
`ifdef CONV_SCHED_PERF_EN
      r_stall_cnt <= '0;
`endif
    end else begin
      r_done     <= 1'b0;
      r_agen_rst <= 1'b0;
      r_addr_inc <= 1'b0;
      r_out      <= w_out_nxt;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (w_cfg_bad) begin
              r_cfg_err <= 1'b1;
              r_done    <= 1'b1;
            end else begin
              r_width    <= bus.width;
              r_channel  <= bus.channel;
              r_stride   <= bus.stride;
              r_cfg_err  <= 1'b0;
              r_agen_rst <= 1'b1;
              r_busy     <= 1'b1;
              r_state    <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          r_col      <= '0;
          r_row      <= '0;
          r_chan     <= '0;
          r_addr_inc <= w_out_nxt < c_CREDITS;
`ifdef CONV_SCHED_PERF_EN
          r_stall_cnt <= '0;
`endif
          r_state    <= S_RUN;
        end
        S_RUN: begin
          if (w_issue) begin
            if (w_row_end) begin
              r_col <= '0;
              if (w_chan_end) begin
                r_row  <= '0;
                r_chan <= r_chan + CNT_W'(1);
              end else begin
                r_row <= r_row + CNT_W'(r_stride);
              end
            end else begin
              r_col <= r_col + CNT_W'(r_stride);
            end
          end
`ifdef CONV_SCHED_PERF_EN
          if (!w_issue) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
          end
`endif
          if (w_issue && w_layer_end) begin
            r_state <= S_DRAIN;
          end else begin
            r_addr_inc <= w_out_nxt < c_CREDITS;
          end
        end
        S_DRAIN: begin
          if (r_out == '0) begin
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end
        end
        S_FIN: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Issue pipeline: tail marks read data present at the BRAM outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_sr  <= '0;
      r_last_sr <= '0;
    end else begin
      r_vld_sr[0]  <= w_issue;
      r_last_sr[0] <= w_issue && w_chan_end;
      for (int i = 1; i < BRAM_LAT; i++) begin
        r_vld_sr[i]  <= r_vld_sr[i-1];
        r_last_sr[i] <= r_last_sr[i-1];
      end
    end
  end

  assign bus.agen_rst  = r_agen_rst;
  assign bus.addr_inc  = r_addr_inc;
  assign bus.win_valid = r_vld_sr[BRAM_LAT-1];
  assign bus.win_last  = r_last_sr[BRAM_LAT-1];
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.cfg_err   = r_cfg_err;
`ifdef CONV_SCHED_PERF_EN
  assign bus.stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_conv_win_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_conv_win_sched : randomized self-checking bench for conv_win_sched      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_conv_win_sched;
  localparam int BRAM_LAT = 2;
  localparam int CREDITS  = 4;
  localparam int CNT_W    = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  conv_win_sched_if #(.CNT_W(CNT_W)) bif ();

  conv_win_sched #(.BRAM_LAT(BRAM_LAT), .CREDITS(CREDITS), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  int checks = 0;
  int errors = 0;

  // Monitor state and expectations derived from the layer geometry
  int cyc = 0;
  int exp_per_chan = 1;
  int exp_total = 0;
  int mon_inc, mon_valid, mon_last, mon_done, mon_busy, mon_agen, mon_stall;
  int first_inc_cyc, last_inc_cyc, first_val_cyc, agen_cyc;
  int model_out = 0;
  logic [7:0] hist = '0;
  bit exp_last;

  task automatic mon_clear();
    mon_inc = 0; mon_valid = 0; mon_last = 0; mon_done = 0;
    mon_busy = 0; mon_agen = 0; mon_stall = 0;
    first_inc_cyc = -1; last_inc_cyc = -1; first_val_cyc = -1; agen_cyc = -1;
  endtask

  task automatic set_expect(input int w, input int c, input int s);
    int per_row;
    per_row = (w - 3) / s + 1;
    exp_per_chan = per_row * per_row;
    exp_total = exp_per_chan * c;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      hist = '0;
      model_out = 0;
    end else begin
      checks++;
      if (bif.win_valid !== hist[BRAM_LAT-1]) begin
        errors++;
        $display("FAIL latency: win_valid=%b required %b (cycle %0d)", bif.win_valid, hist[BRAM_LAT-1], cyc);
      end
      if (bif.addr_inc) begin
        checks++;
        if (model_out >= CREDITS) begin
          errors++;
          $display("FAIL credit: addr_inc with %0d outstanding, limit %0d", model_out, CREDITS);
        end
        if (mon_inc == 0) first_inc_cyc = cyc;
        last_inc_cyc = cyc;
      end else if (mon_inc > 0 && mon_inc < exp_total) begin
        mon_stall++;
      end
      if (bif.addr_inc) mon_inc++;
      if (bif.win_valid) begin
        exp_last = ((mon_valid + 1) % exp_per_chan) == 0;
        checks++;
        if (bif.win_last !== exp_last) begin
          errors++;
          $display("FAIL win_last: window %0d got %b required %b", mon_valid + 1, bif.win_last, exp_last);
        end
        if (bif.win_last) mon_last++;
        if (mon_valid == 0) first_val_cyc = cyc;
        mon_valid++;
      end
      if (bif.done) mon_done++;
      if (bif.busy) mon_busy++;
      if (bif.agen_rst) begin
        mon_agen++;
        agen_cyc = cyc;
      end
      if (bif.addr_inc && !bif.win_ready) model_out++;
      else if (!bif.addr_inc && bif.win_ready && model_out > 0) model_out--;
      hist = {hist[6:0], bif.addr_inc};
    end
  end

  task automatic start_layer(input int w, input int c, input int s);
    @(posedge clk); #1;
    bif.width   = CNT_W'(w);
    bif.channel = CNT_W'(c);
    bif.stride  = 3'(s);
    bif.start   = 1'b1;
    @(posedge clk); #1;
    bif.start   = 1'b0;
  endtask

  task automatic run_until_done(input bit rnd, input int budget);
    int n;
    n = 0;
    while (mon_done == 0 && n < budget) begin
      @(posedge clk); #1;
      if (rnd) bif.win_ready = 1'($urandom_range(0, 1));
      n++;
    end
    checks++;
    if (mon_done == 0) begin
      errors++;
      $display("FAIL timeout: no done within %0d cycles", budget);
    end
    repeat (BRAM_LAT + 3) @(posedge clk);
    #1;
    bif.win_ready = 1'b1;
  endtask

  task automatic test_reset();
    logic [6:0] outs;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    outs = {bif.agen_rst, bif.addr_inc, bif.win_valid, bif.win_last, bif.busy, bif.done, bif.cfg_err};
    checks++;
    if (outs !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 0000000", outs);
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bif.busy !== 1'b0 || bif.addr_inc !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b addr_inc=%b required 0 0", bif.busy, bif.addr_inc);
    end
  endtask

  task automatic test_basic();
    mon_clear();
    set_expect(5, 1, 1);
    bif.win_ready = 1'b1;
    start_layer(5, 1, 1);
    run_until_done(1'b0, 200);
    checks += 7;
    if (mon_inc != 9) begin errors++; $display("FAIL basic_inc: got %0d required 9", mon_inc); end
    if (mon_valid != 9) begin errors++; $display("FAIL basic_valid: got %0d required 9", mon_valid); end
    if (mon_last != 1) begin errors++; $display("FAIL basic_last: got %0d required 1", mon_last); end
    if (mon_done != 1) begin errors++; $display("FAIL basic_done: got %0d required 1", mon_done); end
    if (first_val_cyc - first_inc_cyc != BRAM_LAT) begin
      errors++; $display("FAIL basic_latency: got %0d required %0d", first_val_cyc - first_inc_cyc, BRAM_LAT);
    end
    if (last_inc_cyc - first_inc_cyc != 8) begin
      errors++; $display("FAIL back_to_back: issue span %0d required 8", last_inc_cyc - first_inc_cyc);
    end
    if (mon_agen != 1 || first_inc_cyc - agen_cyc != 1) begin
      errors++; $display("FAIL agen_rst: pulses %0d lead %0d required 1 1", mon_agen, first_inc_cyc - agen_cyc);
    end
    checks++;
    if (bif.busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b required 0", bif.busy); end
  endtask

  task automatic test_geometry();
    int w_t[3] = '{8, 7, 6};
    int c_t[3] = '{2, 1, 3};
    int s_t[3] = '{2, 4, 3};
    for (int i = 0; i < 3; i++) begin
      mon_clear();
      set_expect(w_t[i], c_t[i], s_t[i]);
      bif.win_ready = 1'b1;
      start_layer(w_t[i], c_t[i], s_t[i]);
      run_until_done(1'b0, 400);
      checks += 3;
      if (mon_inc != exp_total || mon_valid != exp_total) begin
        errors++; $display("FAIL geom%0d_windows: inc %0d valid %0d required %0d", i, mon_inc, mon_valid, exp_total);
      end
      if (mon_last != c_t[i]) begin
        errors++; $display("FAIL geom%0d_last: got %0d required %0d", i, mon_last, c_t[i]);
      end
      if (mon_done != 1) begin
        errors++; $display("FAIL geom%0d_done: got %0d required 1", i, mon_done);
      end
    end
  endtask

  task automatic test_random();
    int w, c, s;
    for (int i = 0; i < 6; i++) begin
      w = $urandom_range(3, 12);
      s = $urandom_range(1, 4);
      c = $urandom_range(1, 3);
      mon_clear();
      set_expect(w, c, s);
      start_layer(w, c, s);
      run_until_done(1'b1, 3000);
      checks += 3;
      if (mon_inc != exp_total || mon_valid != exp_total) begin
        errors++; $display("FAIL rand%0d_windows: w=%0d c=%0d s=%0d inc %0d valid %0d required %0d", i, w, c, s, mon_inc, mon_valid, exp_total);
      end
      if (mon_last != c) begin
        errors++; $display("FAIL rand%0d_last: got %0d required %0d", i, mon_last, c);
      end
      if (mon_done != 1) begin
        errors++; $display("FAIL rand%0d_done: got %0d required 1", i, mon_done);
      end
    end
  endtask

  task automatic test_credit_stall();
    mon_clear();
    set_expect(8, 1, 1);
    bif.win_ready = 1'b0;
    start_layer(8, 1, 1);
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (mon_inc != CREDITS) begin errors++; $display("FAIL stall_count: got %0d required %0d", mon_inc, CREDITS); end
    bif.win_ready = 1'b1;
    @(posedge clk); #1;
    bif.win_ready = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (mon_inc != CREDITS + 1) begin errors++; $display("FAIL one_credit: got %0d required %0d", mon_inc, CREDITS + 1); end
    bif.win_ready = 1'b1;
    run_until_done(1'b0, 400);
    checks++;
    if (mon_inc != 36 || mon_done != 1) begin
      errors++; $display("FAIL stall_finish: inc %0d done %0d required 36 1", mon_inc, mon_done);
    end
`ifdef CONV_SCHED_PERF_EN
    checks++;
    if (bif.stall_cnt !== 32'(mon_stall)) begin
      errors++; $display("FAIL stall_cnt: got %0d required %0d", bif.stall_cnt, mon_stall);
    end
`endif
  endtask

  task automatic test_cfg_err();
    int w_t[4] = '{2, 5, 5, 5};
    int c_t[4] = '{1, 0, 1, 1};
    int s_t[4] = '{1, 1, 0, 5};
    for (int i = 0; i < 4; i++) begin
      mon_clear();
      start_layer(w_t[i], c_t[i], s_t[i]);
      repeat (4) @(posedge clk);
      #1;
      checks += 2;
      if (bif.cfg_err !== 1'b1 || mon_done != 1) begin
        errors++; $display("FAIL cfg_err%0d: cfg_err %b done %0d required 1 1", i, bif.cfg_err, mon_done);
      end
      if (mon_busy != 0 || mon_inc != 0) begin
        errors++; $display("FAIL cfg_idle%0d: busy cycles %0d inc %0d required 0 0", i, mon_busy, mon_inc);
      end
    end
    mon_clear();
    set_expect(5, 1, 1);
    start_layer(5, 1, 1);
    run_until_done(1'b1, 400);
    checks++;
    if (bif.cfg_err !== 1'b0 || mon_inc != 9) begin
      errors++; $display("FAIL cfg_clear: cfg_err %b inc %0d required 0 9", bif.cfg_err, mon_inc);
    end
  endtask

  task automatic test_start_while_busy();
    mon_clear();
    set_expect(5, 1, 1);
    start_layer(5, 1, 1);
    repeat (3) @(posedge clk);
    start_layer(9, 2, 1);
    run_until_done(1'b1, 400);
    checks++;
    if (mon_inc != 9 || mon_done != 1 || mon_agen != 1) begin
      errors++; $display("FAIL busy_start: inc %0d done %0d agen %0d required 9 1 1", mon_inc, mon_done, mon_agen);
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] outs;
    mon_clear();
    set_expect(5, 1, 1);
    bif.win_ready = 1'b1;
    start_layer(5, 1, 1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    outs = {bif.agen_rst, bif.addr_inc, bif.win_valid, bif.win_last, bif.busy, bif.done, bif.cfg_err};
    checks++;
    if (outs !== 7'b0) begin errors++; $display("FAIL async_reset: got %b required 0000000", outs); end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (mon_done != 0) begin errors++; $display("FAIL reset_no_done: got %0d required 0", mon_done); end
    mon_clear();
    start_layer(5, 1, 1);
    run_until_done(1'b0, 200);
    checks++;
    if (mon_inc != 9 || mon_valid != 9 || mon_done != 1) begin
      errors++; $display("FAIL rerun: inc %0d valid %0d done %0d required 9 9 1", mon_inc, mon_valid, mon_done);
    end
  endtask

  initial begin
    bif.start = 1'b0; bif.width = '0; bif.channel = '0; bif.stride = '0; bif.win_ready = 1'b0;
    mon_clear();
    test_reset();
    test_basic();
    test_geometry();
    test_random();
    test_credit_stall();
    test_cfg_err();
    test_start_while_busy();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
